// File: rtl/expr_sweep_pkg.sv
// expr_sweep_pkg: shared types, sizes and golden model for the expression sweep.
//   sweep_state_t : controller states
//   NUM_VEC/VEC_W : number and width of the driven input vectors {a,b,c}
//   OBS_W         : width of the observed output word {y4,y3,y2,y1}
//   golden_y()    : reference value of the expression block for one vector
package expr_sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int OBS_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

  // vec = {a,b,c}; result = {y4,y3,y2,y1}
  function automatic logic [OBS_W-1:0] golden_y(input logic [VEC_W-1:0] vec);
    logic a, b, c;
    a = vec[2];
    b = vec[1];
    c = vec[0];
    return {(a | b) & c, a | (b & c), a & c, a | b};
  endfunction

endpackage

// File: rtl/expr_sweep_ctrl_if.sv
// expr_sweep_ctrl_if: record stream from the sweep controller to its consumer.
//   rec_valid : record available (driven by master)
//   rec_ready : consumer accepts record (driven by slave)
//   rec_vec   : vector the record belongs to
//   rec_obs   : observed outputs captured for rec_vec
//   rec_err   : rec_obs differs from the golden value of rec_vec
interface expr_sweep_ctrl_if;
  import expr_sweep_pkg::*;

  logic             rec_valid;
  logic             rec_ready;
  logic [VEC_W-1:0] rec_vec;
  logic [OBS_W-1:0] rec_obs;
  logic             rec_err;

  modport master (
    output rec_valid, rec_vec, rec_obs, rec_err,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_vec, rec_obs, rec_err,
    output rec_ready
  );

endinterface

// File: rtl/expr_golden.sv
// expr_golden: combinational reference model of the expression block.
//   vec : input vector {a,b,c}
//   y   : expected outputs {y4,y3,y2,y1}
module expr_golden
  import expr_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [OBS_W-1:0] y
);

  assign y = golden_y(vec);

endmodule

// File: rtl/expr_sweep_ctrl.sv
// expr_sweep_ctrl: exhaustive sweep sequencer for the 3-input expression block.
// Drives each of the 8 vectors, waits SETTLE_CYCLES, samples obs_y, compares
// against the golden model and streams one record per vector.
//   clk, rst     : clock and synchronous active-high reset
//   start        : sweep request pulse, ignored unless idle
//   busy, done   : sweep in progress / one-cycle end-of-sweep pulse
//   drv_vec      : driven {a,b,c}
//   obs_y        : observed {y4,y3,y2,y1}
//   err_cnt      : saturating mismatch count of the current or last sweep
//   rec          : record stream (master side)
// Build option: STOP_ON_MISMATCH_EN ends the sweep on the first mismatching record.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | drv_vec applied, counting settle cycles
// SAMPLE | record presented, waiting for rec_ready
// DONE   | one-cycle done pulse
module expr_sweep_ctrl
  import expr_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [VEC_W-1:0]    drv_vec,
  input  logic [OBS_W-1:0]    obs_y,
  output logic [ERR_W-1:0]    err_cnt,
  expr_sweep_ctrl_if.master   rec
);

  localparam logic [3:0] SC_LAST = 4'(SETTLE_CYCLES - 1);

  sweep_state_t     state, state_nxt;
  logic [3:0]       sc;
  logic [VEC_W-1:0] rec_vec_q;
  logic [OBS_W-1:0] rec_obs_q;
  logic             rec_err_q;
  logic [OBS_W-1:0] gold_y;
  logic             accept;
  logic             stop_now;

  expr_golden u_golden (
    .vec (drv_vec),
    .y   (gold_y)
  );

  assign accept = (state == SAMPLE) && rec.rec_ready;

`ifdef STOP_ON_MISMATCH_EN
  assign stop_now = (rec_vec_q == VEC_W'(NUM_VEC - 1)) || rec_err_q;
`else
  assign stop_now = (rec_vec_q == VEC_W'(NUM_VEC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (sc == SC_LAST) state_nxt = SAMPLE;
      SAMPLE:  if (accept) state_nxt = stop_now ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_vec   <= '0;
      sc        <= '0;
      err_cnt   <= '0;
      rec_vec_q <= '0;
      rec_obs_q <= '0;
      rec_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            drv_vec <= '0;
            sc      <= '0;
            err_cnt <= '0;
          end
        end
        SETTLE: begin
          sc <= sc + 4'd1;
          if (sc == SC_LAST) begin
            rec_obs_q <= obs_y;
            rec_vec_q <= drv_vec;
            rec_err_q <= (obs_y != gold_y);
          end
        end
        SAMPLE: begin
          if (accept) begin
            if (rec_err_q && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
            // On the final (or stopping) record drv_vec keeps its value.
            if (!stop_now) begin
              drv_vec <= drv_vec + VEC_W'(1);
              sc      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state == SETTLE) || (state == SAMPLE);
  assign done          = (state == DONE);
  assign rec.rec_valid = (state == SAMPLE);
  assign rec.rec_vec   = rec_vec_q;
  assign rec.rec_obs   = rec_obs_q;
  assign rec.rec_err   = rec_err_q;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// tb_expr_sweep_ctrl: directed bench for expr_sweep_ctrl.
// A table-driven stand-in for the expression block answers drv_vec with a
// correct, a y3-faulty or an all-zero output word. A second instance with
// ERR_W=2 checks counter saturation.
module tb_expr_sweep_ctrl;
  import expr_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start, start2;
  logic busy, done, busy2, done2;
  logic [2:0] drv_vec, drv2;
  logic [3:0] obs_y;
  logic [3:0] err_cnt;
  logic [1:0] err_cnt2;
  int mode;

  expr_sweep_ctrl_if rec_if ();
  expr_sweep_ctrl_if rec2_if ();

  expr_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .drv_vec(drv_vec), .obs_y(obs_y), .err_cnt(err_cnt), .rec(rec_if)
  );

  expr_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .drv_vec(drv2), .obs_y(4'h0), .err_cnt(err_cnt2), .rec(rec2_if)
  );

  always #5 clk = ~clk;

  // Hand-derived output words {y4,y3,y2,y1} for vectors 0..7.
  logic [3:0] obs_good [8] = '{4'h0, 4'h0, 4'h1, 4'hD, 4'h5, 4'hF, 4'h5, 4'hF};
  logic [3:0] obs_bad  [8] = '{4'h0, 4'h0, 4'h1, 4'hD, 4'h1, 4'hF, 4'h1, 4'hF};
  logic [3:0] obs_zero [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       err_none [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       err_bad  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       err_zero [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  always_comb begin
    obs_y = 4'h0;
    case (mode)
      0: obs_y = obs_good[drv_vec];
      1: obs_y = obs_bad[drv_vec];
      default: obs_y = 4'h0;
    endcase
  end

  int total = 0;
  int bad = 0;

  logic [7:0] rec_log [16];
  int   nrec, ndone, done_cyc, stall_good;
  logic busy1, busy_after;
  logic timeout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_recs(input string tag, input int n,
                          input logic [3:0] obs_t [8], input logic err_t [8]);
    for (int i = 0; i < n && i < 8; i++)
      chk($sformatf("%s_rec%0d", tag, i), {24'h0, rec_log[i]},
          {24'h0, 3'(i), obs_t[i], err_t[i]});
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge of the
  // cycle after done, so a following call starts in that cycle.
  task automatic run_sweep(input int stall_vec, input int stall_n,
                           input int restart_at, input bit start_on_done);
    int cyc, stalls;
    nrec = 0; ndone = 0; done_cyc = 0; stall_good = 0; stalls = 0; timeout = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy1 = busy;
    forever begin
      if (cyc > 400) begin timeout = 1'b1; start = 1'b0; break; end
      if (ndone > 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        start = 1'b0;
        rec_if.rec_ready = 1'b1;
        break;
      end
      start = (cyc == restart_at);
      if (done) begin
        if (ndone == 0) done_cyc = cyc;
        ndone++;
        start = start | start_on_done;
      end
      rec_if.rec_ready = 1'b1;
      if (rec_if.rec_valid && (32'(rec_if.rec_vec) == stall_vec) && stalls < stall_n) begin
        rec_if.rec_ready = 1'b0;
        stalls++;
        if (32'(drv_vec) == stall_vec) stall_good++;
      end
      if (rec_if.rec_valid && rec_if.rec_ready) begin
        if (nrec < 16) rec_log[nrec] = {rec_if.rec_vec, rec_if.rec_obs, rec_if.rec_err};
        nrec++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int w;
    logic saw_done;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
    rec_if.rec_ready = 1'b1;
    rec2_if.rec_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_state",
        {16'h0, busy, done, rec_if.rec_valid, rec_if.rec_err, drv_vec,
         rec_if.rec_vec, rec_if.rec_obs, err_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Clean sweep; start also held high in the done cycle.
    mode = 0;
    run_sweep(-1, 0, -1, 1'b1);
    chk("s1_timeout", 32'(timeout), 0);
    chk("s1_busy_first", 32'(busy1), 1);
    chk("s1_nrec", nrec, 8);
    chk("s1_done_cyc", done_cyc, 25);
    chk("s1_start_at_done_ignored", 32'(busy_after), 0);
    chk("s1_err_cnt", 32'(err_cnt), 0);
    chk("s1_drv_hold", 32'(drv_vec), 7);
    chk_recs("s1", nrec, obs_good, err_none);

    // Started the cycle after done; start re-pulsed at cycle 10.
    run_sweep(-1, 0, 10, 1'b0);
    chk("s2_timeout", 32'(timeout), 0);
    chk("s2_nrec", nrec, 8);
    chk("s2_ndone", ndone, 1);
    chk("s2_done_cyc", done_cyc, 25);
    chk_recs("s2", nrec, obs_good, err_none);

    // y3 implemented as (a|b)&c.
    mode = 1;
    run_sweep(-1, 0, -1, 1'b0);
    chk("s3_timeout", 32'(timeout), 0);
`ifdef STOP_ON_MISMATCH_EN
    chk("s3_nrec", nrec, 5);
    chk("s3_done_cyc", done_cyc, 16);
    chk("s3_err_cnt", 32'(err_cnt), 1);
    chk("s3_drv_vec", 32'(drv_vec), 4);
`else
    chk("s3_nrec", nrec, 8);
    chk("s3_done_cyc", done_cyc, 25);
    chk("s3_err_cnt", 32'(err_cnt), 2);
`endif
    chk_recs("s3", nrec, obs_bad, err_bad);

    // Backpressure: 5 stalled cycles on vector 3.
    mode = 0;
    run_sweep(3, 5, -1, 1'b0);
    chk("s4_timeout", 32'(timeout), 0);
    chk("s4_stall_hold", stall_good, 5);
    chk("s4_nrec", nrec, 8);
    chk("s4_done_cyc", done_cyc, 30);
    chk_recs("s4", nrec, obs_good, err_none);

    // Outputs stuck at zero.
    mode = 2;
    run_sweep(-1, 0, -1, 1'b0);
    chk("s5_timeout", 32'(timeout), 0);
`ifdef STOP_ON_MISMATCH_EN
    chk("s5_nrec", nrec, 3);
    chk("s5_err_cnt", 32'(err_cnt), 1);
    chk("s5_drv_vec", 32'(drv_vec), 2);
`else
    chk("s5_nrec", nrec, 8);
    chk("s5_err_cnt", 32'(err_cnt), 6);
`endif
    chk_recs("s5", nrec, obs_zero, err_zero);

    // Reset during vector 5 settle.
`ifdef STOP_ON_MISMATCH_EN
    mode = 0;
`else
    mode = 1;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (w = 0; w < 100; w++) begin
      if (drv_vec == 3'd5 && !rec_if.rec_valid) break;
      @(negedge clk);
    end
    chk("s6_reach_vec5", 32'(w < 100), 1);
`ifndef STOP_ON_MISMATCH_EN
    chk("s6_err_before_rst", 32'(err_cnt), 1);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_after_rst", {20'h0, busy, done, rec_if.rec_valid, drv_vec, err_cnt}, 32'h0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    chk("s6_no_done", 32'(saw_done), 0);
    mode = 0;
    run_sweep(-1, 0, -1, 1'b0);
    chk("s6_timeout", 32'(timeout), 0);
    chk("s6_nrec", nrec, 8);
    chk("s6_done_cyc", done_cyc, 25);
    chk("s6_err_cnt", 32'(err_cnt), 0);
    chk_recs("s6", nrec, obs_good, err_none);

    // ERR_W=2 instance with zero outputs.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (w = 0; w < 100; w++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("s7_done_seen", 32'(w < 100), 1);
`ifdef STOP_ON_MISMATCH_EN
    chk("s7_err_cnt_w2", 32'(err_cnt2), 1);
`else
    chk("s7_err_cnt_w2_sat", 32'(err_cnt2), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
